mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory access controller sitting directly upstream of the 16x8 data memory in the 8-bit microprocessor. It accepts read/write requests from the core on a valid/ready handshake and sequences the memory's `mem_enable`/`read_write`/address/data pins. Each accepted request becomes one or more single-byte beats at auto-incrementing addresses. Read data returns as a registered one-cycle strobe, and a `done` pulse marks transaction completion.

## Interface
- `ADDR_W`, 4: memory address width.
- `DATA_W`, 8: data byte width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present; held stable until accepted.
- `req_ready` out 1: high only in IDLE and not in reset.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: first beat address.
- `req_len` in 2: beats minus 1 (0..3).
- `wdata` in DATA_W: write beat data.
- `wdata_valid` in 1: write beat available.
- `wdata_ready` out 1: write beat accepted when both high.
- `rdata` out DATA_W: read beat data, registered.
- `rdata_valid` out 1: one-cycle strobe per read beat; no backpressure.
- `done` out 1: one-cycle completion pulse.
- `mem_addr` out ADDR_W: to memory `address_bus`.
- `mem_enable` out 1: to memory `mem_enable`.
- `mem_rw` out 1: to memory `read_write` (1 = read).
- `mem_wdata` out DATA_W: write data toward the bus.
- `mem_wdata_oe` out 1: top-level tri-state enable for `mem_wdata`.
- `mem_rdata` in DATA_W: bus value as seen by the controller.

## Operation
- States: IDLE, RD_REQ, RD_CAP, WR_WAIT, WR_DO, DONE.
- Acceptance: in IDLE, `req_valid` high causes acceptance. The block latches `cur_addr`=`req_addr`, `beats_left`=`req_len`, and direction. Next state is RD_REQ for a read or WR_WAIT for a write.
- RD_REQ: drives `mem_enable`=1, `mem_rw`=1, `mem_addr`=`cur_addr`. Memory latches the byte at the end of this cycle. Next state is RD_CAP.
- RD_CAP: drives `mem_enable`=0, `mem_rw`=1. It registers `mem_rdata` into `rdata` and sets `rdata_valid` for the following cycle. If `beats_left`=0, next state is DONE. Otherwise it decrements `beats_left`, increments `cur_addr`, and returns to RD_REQ.
- WR_WAIT: `wdata_ready`=1. On `wdata_valid`, it captures `wdata` into `mem_wdata` and moves to WR_DO.
- WR_DO: drives `mem_enable`=1, `mem_rw`=0, `mem_wdata_oe`=1. Memory writes at the end of this cycle. Next state is DONE if this was the last beat; otherwise it decrements, increments the address and returns to WR_WAIT.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W: address 15 increments to 0 with no error.
- `mem_rw` is 1 and `mem_wdata_oe` is 0 in every state except WR_DO.
- `req_valid` outside IDLE and `wdata_valid` outside WR_WAIT are ignored.

## Timing
- Reset values:
  - Control: state IDLE, `req_ready` 0 while `rst`=1, `wdata_ready` 0, `done` 0.
  - Memory pins: `mem_enable` 0, `mem_rw` 1, `mem_addr` 0, `mem_wdata` 0, `mem_wdata_oe` 0.
  - Read return: `rdata` 0, `rdata_valid` 0.
- Read with acceptance at edge E0:
  - RD_REQ occupies cycle 1 and RD_CAP cycle 2.
  - Cycle 3 has `rdata_valid`, and `done` for the last beat.
  - Each additional beat adds 2 cycles, and each `rdata_valid` is separated by 2 cycles.
- Write with `wdata_valid` already high:
  - WR_WAIT is cycle 1, WR_DO cycle 2, and `done` cycle 3.
  - Each additional beat adds 2 cycles plus any `wdata_valid` stall.
- The next request can be accepted in the cycle after `done`.
- Reset mid-transaction:
  - Aborts at the next edge and deasserts `mem_enable` immediately.
  - No `rdata_valid` or `done` is emitted afterwards.
  - Beats already written remain in memory.

## Configuration
- `MEM_CTRL_BURST_EN` defined: `req_len` is honoured, giving 1..4 beats.
- `MEM_CTRL_BURST_EN` undefined:
  - The `req_len` port remains but is ignored, so every transaction is one beat.
  - `beats_left` logic is removed.

## Structure
- `mem_ctrl_pkg` holds:
  - the state enum;
  - `ADDR_W`/`DATA_W` defaults;
  - the read/write encoding constants (`MEM_READ`=1, `MEM_WRITE`=0).
- There is no sub-module: the FSM, address counter and beat counter live in `mem_ctrl`. Tri-state resolution against the memory's `inout` bus is done at top level.

## Test plan
- Reset state: hold `rst` for 3 cycles → every output matches its reset value, and `req_ready`=0 until the cycle after `rst` falls.
- Single write then read: write `req_addr`=5 with `wdata`=0xA5, then read `req_addr`=5 → `done` at cycle 3 of each, and `rdata`=0xA5 with `rdata_valid` at cycle 3 of the read.
- Burst wrap (burst enabled): write `req_len`=3 at address 14 with data 0x11, 0x22, 0x33, 0x44 → bytes land at addresses 14, 15, 0, 1. A 4-beat read from 14 returns them in order, with strobes 2 cycles apart.
- Write data stall: hold `wdata_valid` low for 4 cycles in WR_WAIT → `mem_enable` stays 0 during the stall, and the write completes 2 cycles after `wdata_valid` rises.
- Busy and stray inputs: pulse `req_valid` and `wdata_valid` during a read burst → neither is accepted and no memory write occurs.
- Reset mid-burst: assert `rst` in RD_CAP of beat 2 → no further `rdata_valid` or `done`, and IDLE is restored after reset.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller in front of the 16x8 data memory.
// Burst support in mem_ctrl is enabled by defining MEM_CTRL_BURST_EN.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // Memory read_write pin encoding
    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_CAP  = 3'd2,
        WR_WAIT = 3'd3,
        WR_DO   = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Memory access controller: turns core read/write requests into single-byte memory beats.
// Define MEM_CTRL_BURST_EN to honour req_len (1..4 beats); otherwise every request is one beat.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] cur_addr_r;
    logic              accept_s;
    logic              last_beat_s;
    logic              step_s;
    logic              en_nxt_s;
    logic              rw_nxt_s;
    logic              oe_nxt_s;
    logic              wready_nxt_s;
    logic              rready_nxt_s;
    logic              done_nxt_s;

`ifdef MEM_CTRL_BURST_EN
    logic [1:0]        beats_left_r;
    assign last_beat_s = (beats_left_r == 2'd0);
`else
    logic              unused_len_s;
    assign unused_len_s = ^req_len;
    assign last_beat_s  = 1'b1;
`endif

    assign accept_s = (state_r == IDLE) && req_valid && req_ready;
    assign step_s   = ((state_r == RD_CAP) || (state_r == WR_DO)) && !last_beat_s;
    assign mem_addr = cur_addr_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = req_write ? WR_WAIT : RD_REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_REQ:  next_state_s = RD_CAP;
            RD_CAP:  next_state_s = last_beat_s ? DONE : RD_REQ;
            WR_WAIT: begin
                if (wdata_valid) begin
                    next_state_s = WR_DO;
                end else begin
                    next_state_s = WR_WAIT;
                end
            end
            WR_DO:   next_state_s = last_beat_s ? DONE : WR_WAIT;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Pin values for the upcoming state, registered below so outputs come straight from flops
    always_comb begin
        en_nxt_s     = 1'b0;
        rw_nxt_s     = MEM_READ;
        oe_nxt_s     = 1'b0;
        wready_nxt_s = 1'b0;
        rready_nxt_s = 1'b0;
        done_nxt_s   = 1'b0;
        case (next_state_s)
            IDLE:    rready_nxt_s = 1'b1;
            RD_REQ:  en_nxt_s     = 1'b1;
            WR_WAIT: wready_nxt_s = 1'b1;
            WR_DO: begin
                en_nxt_s = 1'b1;
                rw_nxt_s = MEM_WRITE;
                oe_nxt_s = 1'b1;
            end
            DONE:    done_nxt_s   = 1'b1;
            default: en_nxt_s     = 1'b0;
        endcase
    end

    // Address/beat counters, data capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_r   <= '0;
`ifdef MEM_CTRL_BURST_EN
            beats_left_r <= 2'd0;
`endif
            mem_enable   <= 1'b0;
            mem_rw       <= MEM_READ;
            mem_wdata_oe <= 1'b0;
            mem_wdata    <= '0;
            wdata_ready  <= 1'b0;
            req_ready    <= 1'b0;
            done         <= 1'b0;
            rdata        <= '0;
            rdata_valid  <= 1'b0;
        end else begin
            if (accept_s) begin
                cur_addr_r   <= req_addr;
`ifdef MEM_CTRL_BURST_EN
                beats_left_r <= req_len;
`endif
            end else if (step_s) begin
                // Wraps modulo 2^ADDR_W by construction
                cur_addr_r   <= cur_addr_r + ADDR_W'(1);
`ifdef MEM_CTRL_BURST_EN
                beats_left_r <= beats_left_r - 2'd1;
`endif
            end
            if ((state_r == WR_WAIT) && wdata_valid) begin
                mem_wdata <= wdata;
            end
            if (state_r == RD_CAP) begin
                rdata <= mem_rdata;
            end
            rdata_valid  <= (state_r == RD_CAP);
            mem_enable   <= en_nxt_s;
            mem_rw       <= rw_nxt_s;
            mem_wdata_oe <= oe_nxt_s;
            wdata_ready  <= wready_nxt_s;
            req_ready    <= rready_nxt_s;
            done         <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: transaction-level expected-pin model, 16x8 memory device, random traffic.
// Works with and without MEM_CTRL_BURST_EN defined.
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [1:0] req_len = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       done;
    logic [3:0] mem_addr;
    logic       mem_enable;
    logic       mem_rw;
    logic [7:0] mem_wdata;
    logic       mem_wdata_oe;
    logic [7:0] mem_rdata;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_rw(mem_rw),
        .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
    );

    // 16x8 memory device: latches read byte at end of an enabled read cycle
    logic [7:0] dev_mem [16] = '{default: 8'h00};
    logic [7:0] dev_out = 8'h00;
    int         dev_writes = 0;
    assign mem_rdata = dev_out;

    always @(posedge clk) begin
        if (mem_enable && mem_rw) dev_out <= dev_mem[mem_addr];
        if (mem_enable && !mem_rw && mem_wdata_oe) begin
            dev_mem[mem_addr] <= mem_wdata;
            dev_writes <= dev_writes + 1;
        end
    end

    // Latency / strobe-spacing monitor
    int         cyc = 0, acc_cyc = 0, lat = 0, last_rv_cyc = 0, rv_gap = 0;
    logic [7:0] last_rdata = 8'h00;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) acc_cyc <= cyc;
        if (done) lat <= cyc - acc_cyc;
        if (rdata_valid) begin
            rv_gap      <= cyc - last_rv_cyc;
            last_rv_cyc <= cyc;
            last_rdata  <= rdata;
        end
    end

    // Reference model state
    logic [7:0] model_mem [16] = '{default: 8'h00};
    int         exp_writes = 0;
    int         n_checks = 0, n_pass = 0;
    logic       chk = 1'b0;
    logic       e_en, e_rw, e_oe, e_wready, e_rready, e_rv, e_done, e_full;
    logic [3:0] e_addr;
    logic [7:0] e_wd, e_rd;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    endtask

    // Per-cycle compare of every pin against the model's expectation
    always @(negedge clk) begin
        if (chk) begin
            cmp("mem_enable",   {7'd0, mem_enable},   {7'd0, e_en});
            cmp("mem_rw",       {7'd0, mem_rw},       {7'd0, e_rw});
            cmp("mem_wdata_oe", {7'd0, mem_wdata_oe}, {7'd0, e_oe});
            cmp("wdata_ready",  {7'd0, wdata_ready},  {7'd0, e_wready});
            cmp("req_ready",    {7'd0, req_ready},    {7'd0, e_rready});
            cmp("rdata_valid",  {7'd0, rdata_valid},  {7'd0, e_rv});
            cmp("done",         {7'd0, done},         {7'd0, e_done});
            if (e_en || e_full) cmp("mem_addr", {4'd0, mem_addr}, {4'd0, e_addr});
            if (e_oe || e_full) cmp("mem_wdata", mem_wdata, e_wd);
            if (e_rv || e_full) cmp("rdata", rdata, e_rd);
        end
    end

    function automatic int nbeats(input logic [1:0] len);
`ifdef MEM_CTRL_BURST_EN
        return int'(len) + 1;
`else
        return 1;
`endif
    endfunction

    function automatic logic [3:0] wrap(input int x);
        return 4'(x % 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_en = 1'b0; e_rw = 1'b1; e_oe = 1'b0; e_wready = 1'b0; e_rready = 1'b1;
        e_rv = 1'b0; e_done = 1'b0; e_full = 1'b0;
        e_addr = 4'h0; e_wd = 8'h00; e_rd = 8'h00;
    endtask

    task automatic exp_reset();
        exp_idle();
        e_rready = 1'b0;
        e_full   = 1'b1;
    endtask

    // Read of nbeats(len) bytes from a; optional stray inputs; optional reset in RD_CAP of beat rst_beat
    task automatic do_read(input logic [3:0] a, input logic [1:0] len, input bit strays, input int rst_beat);
        int n;
        n = nbeats(len);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_idle(); e_rready = 1'b0; e_en = 1'b1; e_addr = wrap(int'(a) + k);
            if (k > 0) begin
                e_rv = 1'b1;
                e_rd = model_mem[wrap(int'(a) + k - 1)];
            end
            if (strays) begin
                req_valid   = 1'($urandom_range(0, 1));
                wdata_valid = 1'($urandom_range(0, 1));
                wdata       = 8'($urandom);
            end
            step();
            exp_idle(); e_rready = 1'b0;
            if (k == rst_beat) begin
                req_valid = 1'b0; wdata_valid = 1'b0; rst = 1'b1;
                step(); exp_reset();
                step(); exp_reset(); rst = 1'b0;
                step(); exp_idle();
                return;
            end
            step();
        end
        exp_idle(); e_rready = 1'b0; e_done = 1'b1; e_rv = 1'b1;
        e_rd = model_mem[wrap(int'(a) + n - 1)];
        req_valid = 1'b0; wdata_valid = 1'b0;
        step();
        exp_idle();
    endtask

    // Write of nbeats(len) bytes to a; stall<0 picks random stall per beat
    task automatic do_write(input logic [3:0] a, input logic [1:0] len, input int stall,
                            input bit use_dat, input logic [31:0] dat);
        int n, s;
        logic [7:0] d;
        n = nbeats(len);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = len; wdata_valid = 1'b0;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            s = (stall >= 0) ? stall : int'($urandom_range(0, 2));
            for (int i = 0; i < s; i++) begin
                exp_idle(); e_rready = 1'b0; e_wready = 1'b1;
                req_valid = 1'($urandom_range(0, 1));
                step();
            end
            exp_idle(); e_rready = 1'b0; e_wready = 1'b1;
            d = use_dat ? dat[8*k +: 8] : 8'($urandom);
            wdata = d; wdata_valid = 1'b1; req_valid = 1'b0;
            step();
            exp_idle(); e_rready = 1'b0; e_en = 1'b1; e_rw = 1'b0; e_oe = 1'b1;
            e_addr = wrap(int'(a) + k); e_wd = d;
            wdata_valid = 1'b0;
            model_mem[wrap(int'(a) + k)] = d;
            exp_writes++;
            step();
        end
        exp_idle(); e_rready = 1'b0; e_done = 1'b1;
        step();
        exp_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles, then one more cycle before req_ready rises
        step(); exp_reset(); chk = 1'b1;
        step();
        step();
        rst = 1'b0;
        step(); exp_idle();

        do_write(4'd5, 2'd0, 0, 1'b1, 32'h0000_00A5);
        cmp("wr_latency", 8'(lat), 8'd3);
        cmp("mem5_after_write", dev_mem[5], 8'hA5);
        do_read(4'd5, 2'd0, 1'b0, -1);
        cmp("rd_latency", 8'(lat), 8'd3);
        cmp("rd_data_5", last_rdata, 8'hA5);

        do_write(4'd14, 2'd3, 0, 1'b1, 32'h4433_2211);
        cmp("mem14", dev_mem[14], 8'h11);
`ifdef MEM_CTRL_BURST_EN
        cmp("burst_wr_latency", 8'(lat), 8'd9);
        cmp("mem15", dev_mem[15], 8'h22);
        cmp("mem0",  dev_mem[0],  8'h33);
        cmp("mem1",  dev_mem[1],  8'h44);
`else
        cmp("single_wr_latency", 8'(lat), 8'd3);
        cmp("mem15_untouched", dev_mem[15], 8'h00);
`endif
        do_read(4'd14, 2'd3, 1'b0, -1);
`ifdef MEM_CTRL_BURST_EN
        cmp("burst_rd_latency", 8'(lat), 8'd9);
        cmp("burst_rd_last", last_rdata, 8'h44);
        cmp("strobe_gap", 8'(rv_gap), 8'd2);
`else
        cmp("single_rd_data", last_rdata, 8'h11);
`endif

        do_write(4'd9, 2'd0, 4, 1'b1, 32'h0000_005A);
        cmp("stall_latency", 8'(lat), 8'd7);

        do_read(4'd2, 2'd3, 1'b1, -1);
        cmp("no_stray_writes", 8'(dev_writes), 8'(exp_writes));

`ifdef MEM_CTRL_BURST_EN
        do_read(4'd0, 2'd3, 1'b0, 1);
`else
        do_read(4'd0, 2'd3, 1'b0, 0);
`endif
        do_read(4'd14, 2'd0, 1'b0, -1);
        cmp("after_reset_rd", last_rdata, 8'h11);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(4'($urandom), 2'($urandom), -1, 1'b0, 32'h0);
            else
                do_read(4'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), -1);
        end

        cmp("total_writes", 8'(dev_writes), 8'(exp_writes));
        for (int i = 0; i < 16; i++) cmp("final_mem", dev_mem[i], model_mem[i]);

        chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
